// File: rtl/multiplier_pkg.sv
// Shared types and defaults for the sequential shift-add multiplier.
package multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam int MULT_WIDTH_DEFAULT = 2;

endpackage

// File: rtl/multiplier.sv
// Sequential unsigned shift-add multiplier with valid/ready handshakes on both sides.
// One partial product per cycle; the result is held in DONE until the consumer takes it.
module multiplier
    import multiplier_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t          state;
    logic [PW-1:0]   a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [PW-1:0]   acc;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   acc_next;

    // The final edge must see its own partial product, so the sum is formed ahead of the register.
    assign acc_next = b_reg[0] ? (acc + a_reg) : acc;

    assign in_ready = rst_n && (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            cnt       <= '0;
            product   <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= PW'(a);
                        b_reg <= b;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    acc   <= acc_next;
                    a_reg <= a_reg << 1;
                    b_reg <= b_reg >> 1;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        product   <= acc_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench: directed and random operands against a plain a*b reference,
// on a 2-bit instance (default) and an 8-bit instance sharing clock and reset.
module tb_multiplier;

    logic        clk;
    logic        rst_n;

    logic [1:0]  a, b;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  product;

    logic [7:0]  a8, b8;
    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [15:0] product8;

    int nAsserts = 0;
    int nFails   = 0;

    multiplier #(.WIDTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready),
        .product(product), .out_valid(out_valid), .out_ready(out_ready)
    );

    multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .in_valid(in_valid8), .in_ready(in_ready8),
        .product(product8), .out_valid(out_valid8), .out_ready(out_ready8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // One 2-bit operation; when consume is 0 the result is left sitting in DONE.
    task automatic applyStimulus(input logic [1:0] opA, input logic [1:0] opB, input bit consume);
        logic [3:0] expv;
        int edges;
        bit seen;
        expv = {2'b00, opA} * {2'b00, opB};
        a = opA;
        b = opB;
        in_valid = 1'b1;
        checkOutput("in_ready_idle", in_ready, 1);
        nextCycle();
        in_valid = 1'b0;
        a = 2'($urandom);
        b = 2'($urandom);
        edges = 0;
        seen = 0;
        repeat (20) begin
            if (!seen) begin
                nextCycle();
                edges++;
                checkOutput("in_ready_busy", in_ready, 0);
                if (out_valid) seen = 1;
            end
        end
        checkOutput("latency_w2", edges, 2);
        checkOutput("product_w2", product, expv);
        if (consume) begin
            nextCycle();
            checkOutput("out_valid_drop", out_valid, 0);
            checkOutput("in_ready_back", in_ready, 1);
        end
    endtask

    task automatic applyStimulus8(input logic [7:0] opA, input logic [7:0] opB);
        logic [15:0] expv;
        int edges;
        bit seen;
        expv = {8'h00, opA} * {8'h00, opB};
        a8 = opA;
        b8 = opB;
        in_valid8 = 1'b1;
        nextCycle();
        in_valid8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        edges = 0;
        seen = 0;
        repeat (40) begin
            if (!seen) begin
                nextCycle();
                edges++;
                if (in_ready8) checkOutput("in_ready8_busy", in_ready8, 0);
                if (out_valid8) seen = 1;
            end
        end
        checkOutput("latency_w8", edges, 8);
        checkOutput("product_w8", product8, expv);
        nextCycle();
        checkOutput("out_valid8_drop", out_valid8, 0);
    endtask

    initial begin
        logic [3:0] q[$];
        logic [3:0] e;
        int issued;
        int received;

        rst_n = 1'b0;
        a = '0; b = '0; in_valid = 1'b0; out_ready = 1'b1;
        a8 = '0; b8 = '0; in_valid8 = 1'b0; out_ready8 = 1'b1;

        $display("[TB] reset phase");
        #12;
        checkOutput("rst_in_ready_low", in_ready, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_product", product, 0);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_in_ready_high", in_ready, 1);
        nextCycle();

        $display("[TB] directed products");
        applyStimulus(2'b10, 2'b11, 1);
        applyStimulus(2'b01, 2'b00, 1);
        applyStimulus(2'b11, 2'b11, 1);
        applyStimulus(2'b01, 2'b10, 1);

        $display("[TB] exhaustive 2x2");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(2'(i >> 2), 2'(i), 1);
        end

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(2'b11, 2'b11, 0);
        for (int i = 0; i < 5; i++) begin
            a = 2'($urandom);
            b = 2'($urandom);
            in_valid = ~in_valid;
            nextCycle();
            checkOutput("bp_out_valid", out_valid, 1);
            checkOutput("bp_product", product, 9);
            checkOutput("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        nextCycle();
        checkOutput("bp_release_valid", out_valid, 0);
        checkOutput("bp_release_ready", in_ready, 1);

        $display("[TB] reset mid-operation");
        a = 2'd3;
        b = 2'd2;
        in_valid = 1'b1;
        nextCycle();
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_product", product, 0);
        checkOutput("midrst_in_ready", in_ready, 0);
        #4;
        rst_n = 1'b1;
        nextCycle();
        applyStimulus(2'd1, 2'd2, 1);

        $display("[TB] back-to-back");
        out_ready = 1'b1;
        issued = 0;
        received = 0;
        for (int cyc = 0; cyc < 200 && (issued < 12 || q.size() > 0); cyc++) begin
            if (out_valid) begin
                if (q.size() == 0) checkOutput("b2b_duplicate", out_valid, 0);
                else begin
                    checkOutput("b2b_product", product, q.pop_front());
                    received++;
                end
            end
            if (in_ready) begin
                if (issued < 12) begin
                    a = 2'($urandom);
                    b = 2'($urandom);
                    in_valid = 1'b1;
                    e = {2'b00, a} * {2'b00, b};
                    q.push_back(e);
                    issued++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            nextCycle();
        end
        in_valid = 1'b0;
        checkOutput("b2b_count", received, 12);
        checkOutput("b2b_drained", q.size(), 0);
        nextCycle();

        $display("[TB] random 8x8");
        applyStimulus8(8'hFF, 8'hFF);
        applyStimulus8(8'h00, 8'hA5);
        for (int i = 0; i < 10; i++) begin
            applyStimulus8(8'($urandom), 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
